// File: rtl/sargantana_icache_valid_ctrl.sv
// ---------------------------------------------------------------------------
// sargantana_icache_valid_ctrl
//
// Purpose:
//   Sequencer and arbiter for the icache valid-bit RAM write port. Three
//   requesters share one write per cycle:
//     - refill       : sets the valid bit of one way in one set
//     - invalidation : clears the valid bit of one way in one set
//     - flush        : walks every set index clearing all ways, stalling
//                      the core for the duration of the walk
//   Accepts and writes happen in the same cycle as the request. Only the FSM
//   state, the flush index counter and the done pulse are registered.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous, active-high reset (aborts a flush silently)
//   flush_req_i    flush request pulse (restarts a walk already in progress)
//   inval_req_i    invalidation request, held until inval_ack_o
//   inval_idx_i    set to invalidate
//   inval_way_i    way to invalidate
//   inval_ack_o    invalidation accepted this cycle
//   refill_req_i   refill valid-set request, held until refill_gnt_o
//   refill_idx_i   refilled set
//   refill_way_i   refilled way
//   refill_gnt_o   refill accepted this cycle
//   valid_we_o     valid RAM write enable
//   valid_addr_o   valid RAM set address
//   valid_wmask_o  per-way write mask
//   valid_wdata_o  bit value written to the masked ways
//   core_stall_o   high while flushing
//   flush_done_o   one-cycle pulse when a flush walk completes
// ---------------------------------------------------------------------------
module sargantana_icache_valid_ctrl #(
  parameter int ICACHE_N_WAY     = 4,
  parameter int ICACHE_IDX_WIDTH = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_req_i,
  input  logic                            inval_req_i,
  input  logic [ICACHE_IDX_WIDTH-1:0]     inval_idx_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0] inval_way_i,
  output logic                            inval_ack_o,
  input  logic                            refill_req_i,
  input  logic [ICACHE_IDX_WIDTH-1:0]     refill_idx_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0] refill_way_i,
  output logic                            refill_gnt_o,
  output logic                            valid_we_o,
  output logic [ICACHE_IDX_WIDTH-1:0]     valid_addr_o,
  output logic [ICACHE_N_WAY-1:0]         valid_wmask_o,
  output logic                            valid_wdata_o,
  output logic                            core_stall_o,
  output logic                            flush_done_o
);

  localparam int WAY_W = $clog2(ICACHE_N_WAY);
  localparam logic [ICACHE_IDX_WIDTH-1:0] CNT_LAST = {ICACHE_IDX_WIDTH{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                      state_q;
  logic [ICACHE_IDX_WIDTH-1:0] cnt_q;
  logic                        flush_done_q;

  // One-hot way decode for the two single-way requesters.
  logic [ICACHE_N_WAY-1:0] refill_onehot;
  logic [ICACHE_N_WAY-1:0] inval_onehot;

  for (genvar gi = 0; gi < ICACHE_N_WAY; gi++) begin : g_way_decode
    assign refill_onehot[gi] = (refill_way_i == WAY_W'(gi));
    assign inval_onehot[gi]  = (inval_way_i  == WAY_W'(gi));
  end

  // -------------------------------------------------------------------------
  // State, flush counter and done pulse.
  // A new flush request always restarts the walk from set 0, even on the
  // last index, so the aborted walk never reports completion.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_req_i) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_req_i) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            flush_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign flush_done_o = flush_done_q;

  // -------------------------------------------------------------------------
  // Write-port mux and handshakes.
  // While flushing, single-way requests are acknowledged without a write:
  // an invalidation is covered by the flush, and a refill may carry a line
  // fetched before the flush began, so it must not become valid.
  // In IDLE, refill wins over invalidation; the loser stays asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    valid_we_o    = 1'b0;
    valid_addr_o  = '0;
    valid_wmask_o = '0;
    valid_wdata_o = 1'b0;
    refill_gnt_o  = 1'b0;
    inval_ack_o   = 1'b0;
    core_stall_o  = 1'b0;

    if (state_q == ST_FLUSH) begin
      valid_we_o    = 1'b1;
      valid_addr_o  = cnt_q;
      valid_wmask_o = '1;
      valid_wdata_o = 1'b0;
      core_stall_o  = 1'b1;
      refill_gnt_o  = refill_req_i;
      inval_ack_o   = inval_req_i;
    end else if (refill_req_i) begin
      valid_we_o    = 1'b1;
      valid_addr_o  = refill_idx_i;
      valid_wmask_o = refill_onehot;
      valid_wdata_o = 1'b1;
      refill_gnt_o  = 1'b1;
    end else if (inval_req_i) begin
      valid_we_o    = 1'b1;
      valid_addr_o  = inval_idx_i;
      valid_wmask_o = inval_onehot;
      valid_wdata_o = 1'b0;
      inval_ack_o   = 1'b1;
    end
  end

endmodule

// File: tb/tb_sargantana_icache_valid_ctrl.sv
module tb_sargantana_icache_valid_ctrl;

  localparam int NW  = 4;
  localparam int IW  = 6;
  localparam int NS  = 1 << IW;

  logic          clk;
  logic          rst;
  logic          flush_req;
  logic          inval_req;
  logic [IW-1:0] inval_idx;
  logic [1:0]    inval_way;
  logic          inval_ack;
  logic          refill_req;
  logic [IW-1:0] refill_idx;
  logic [1:0]    refill_way;
  logic          refill_gnt;
  logic          valid_we;
  logic [IW-1:0] valid_addr;
  logic [NW-1:0] valid_wmask;
  logic          valid_wdata;
  logic          core_stall;
  logic          flush_done;

  sargantana_icache_valid_ctrl #(
    .ICACHE_N_WAY    (NW),
    .ICACHE_IDX_WIDTH(IW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_req_i  (flush_req),
    .inval_req_i  (inval_req),
    .inval_idx_i  (inval_idx),
    .inval_way_i  (inval_way),
    .inval_ack_o  (inval_ack),
    .refill_req_i (refill_req),
    .refill_idx_i (refill_idx),
    .refill_way_i (refill_way),
    .refill_gnt_o (refill_gnt),
    .valid_we_o   (valid_we),
    .valid_addr_o (valid_addr),
    .valid_wmask_o(valid_wmask),
    .valid_wdata_o(valid_wdata),
    .core_stall_o (core_stall),
    .flush_done_o (flush_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vector: {we, addr, wmask, wdata, gnt, ack, stall, done}
  typedef logic [15:0] vec_t;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic vec_t mk(input logic we, input logic [IW-1:0] addr,
                              input logic [NW-1:0] mask, input logic wd,
                              input logic gnt, input logic ack,
                              input logic stall, input logic done);
    return {we, addr, mask, wd, gnt, ack, stall, done};
  endfunction

  // Bench-side image of the valid RAM, built from the write port.
  logic [NW-1:0] shadow [NS];
  always @(posedge clk) begin
    if (valid_we === 1'b1) begin
      for (int w = 0; w < NW; w++)
        if (valid_wmask[w]) shadow[valid_addr][w] <= valid_wdata;
    end
  end

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  e;
      vec_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {valid_we, valid_addr, valid_wmask, valid_wdata,
           refill_gnt, inval_ack, core_stall, flush_done};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got we=%b addr=%0d mask=%b wd=%b gnt=%b ack=%b stall=%b done=%b, want we=%b addr=%0d mask=%b wd=%b gnt=%b ack=%b stall=%b done=%b",
                 n, a[15], a[14:9], a[8:5], a[4], a[3], a[2], a[1], a[0],
                 e[15], e[14:9], e[8:5], e[4], e[3], e[2], e[1], e[0]);
      end else begin
        $display("ok   %s: we=%b addr=%0d mask=%b wd=%b gnt=%b ack=%b stall=%b done=%b",
                 n, a[15], a[14:9], a[8:5], a[4], a[3], a[2], a[1], a[0]);
      end
    end
  end

  // One cycle of stimulus; optionally queue the expected outputs.
  task automatic cyc(input string nm, input logic r, input logic f,
                     input logic rr, input logic [IW-1:0] ri, input logic [1:0] rw,
                     input logic ir, input logic [IW-1:0] ii, input logic [1:0] iw,
                     input logic chk, input vec_t e);
    @(posedge clk);
    #1;
    rst        = r;
    flush_req  = f;
    refill_req = rr;
    refill_idx = ri;
    refill_way = rw;
    inval_req  = ir;
    inval_idx  = ii;
    inval_way  = iw;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic idle(input string nm, input logic done);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, done));
  endtask

  task automatic flush_cyc(input string nm, input int i, input logic f, input logic r);
    cyc(nm, r, f, 0, 0, 0, 0, 0, 0, 1, mk(1, IW'(i), 4'b1111, 0, 0, 0, 1, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_req = 0; inval_req = 0; refill_req = 0;
    inval_idx = 0; inval_way = 0; refill_idx = 0; refill_way = 0;

    // Reset
    cyc("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    cyc("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    idle("after_reset", 0);
    // Index/way ignored without a request
    cyc("idx_no_req", 0, 0, 0, 6'd17, 2'd3, 0, 6'd33, 2'd2, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Refill idx 5 way 2
    cyc("refill_5_2", 0, 0, 1, 6'd5, 2'd2, 0, 0, 0, 1, mk(1, 6'd5, 4'b0100, 1, 1, 0, 0, 0));
    // Refill beats inval; inval held and served next cycle
    cyc("arb_refill", 0, 0, 1, 6'd3, 2'd0, 1, 6'd9, 2'd1, 1, mk(1, 6'd3, 4'b0001, 1, 1, 0, 0, 0));
    cyc("arb_inval",  0, 0, 0, 6'd3, 2'd0, 1, 6'd9, 2'd1, 1, mk(1, 6'd9, 4'b0010, 0, 0, 1, 0, 0));

    // Flush requested together with a refill: refill still served this cycle
    cyc("flush_req_refill", 0, 1, 1, 6'd7, 2'd3, 0, 0, 0, 1, mk(1, 6'd7, 4'b1000, 1, 1, 0, 0, 0));
    for (int i = 0; i < NS; i++) begin
      if (i == 9)
        cyc("flush_w_reqs", 0, 0, 1, 6'd2, 2'd1, 1, 6'd4, 2'd0, 1,
            mk(1, 6'd9, 4'b1111, 0, 1, 1, 1, 0));
      else
        flush_cyc($sformatf("flush_a%0d", i), i, 0, 0);
    end
    idle("flush_done", 1);
    idle("flush_done_clr", 0);

    // After the flush, every valid bit must be clear
    n_cmp++;
    begin
      int bad_set;
      bad_set = -1;
      for (int s = 0; s < NS; s++)
        if (shadow[s] !== 4'b0000 && bad_set < 0) bad_set = s;
      if (bad_set >= 0) begin
        n_bad++;
        $display("FAIL shadow_clear: set %0d valid=%b, want 0000", bad_set, shadow[bad_set]);
      end else begin
        $display("ok   shadow_clear: all sets 0000");
      end
    end

    // Restart at cnt=40
    cyc("restart40_req", 0, 1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= 40; i++)
      flush_cyc($sformatf("flush_b%0d", i), i, i == 40, 0);
    for (int i = 0; i < NS; i++)
      flush_cyc($sformatf("flush_c%0d", i), i, 0, 0);
    idle("restart40_done", 1);
    idle("restart40_done_clr", 0);

    // Restart on the last index: no done for the aborted walk
    cyc("restart63_req", 0, 1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < NS; i++)
      flush_cyc($sformatf("flush_d%0d", i), i, i == NS - 1, 0);
    for (int i = 0; i < NS; i++)
      flush_cyc($sformatf("flush_e%0d", i), i, 0, 0);
    idle("restart63_done", 1);

    // Reset at cnt=20: back to IDLE, no done ever
    cyc("rst20_req", 0, 1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= 20; i++)
      flush_cyc($sformatf("flush_f%0d", i), i, 0, i == 20);
    for (int i = 0; i < 70; i++)
      idle($sformatf("post_rst%0d", i), 0);

    // Drain the scoreboard, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
